// File: rtl/imem_boot_encoder.sv
// Boot-time program loader: encodes symbolic instruction commands into MIPS words
// and writes them to consecutive instruction-memory addresses while holding the CPU.
module imem_boot_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_ill,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_OVF} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                full_q, full_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_ill_q, err_ill_d;
  logic                err_ovf_q, err_ovf_d;
  logic [31:0]         enc_word;
  logic                enc_legal;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Fields a given instruction does not use are zeroed so the image is canonical.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (cmd_op)
      5'd0:    enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'b000000);
      5'd1:    enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'b000010);
      5'd2:    enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'b000011);
      5'd3:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100000);
      5'd4:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100010);
      5'd5:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100100);
      5'd6:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100101);
      5'd7:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100110);
      5'd8:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100111);
      5'd9:    enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b101010);
      5'd10:   enc_word = r_word(cmd_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
      5'd11:   enc_word = {6'b000010, cmd_target};
      5'd12:   enc_word = {6'b000011, cmd_target};
      5'd13:   enc_word = i_word(6'b000100, cmd_rs, cmd_rt, cmd_imm);
      5'd14:   enc_word = i_word(6'b000101, cmd_rs, cmd_rt, cmd_imm);
      5'd15:   enc_word = i_word(6'b001000, cmd_rs, cmd_rt, cmd_imm);
      5'd16:   enc_word = i_word(6'b001100, cmd_rs, cmd_rt, cmd_imm);
      5'd17:   enc_word = i_word(6'b001101, cmd_rs, cmd_rt, cmd_imm);
      5'd18:   enc_word = i_word(6'b001110, cmd_rs, cmd_rt, cmd_imm);
      5'd19:   enc_word = i_word(6'b100011, cmd_rs, cmd_rt, cmd_imm);
      5'd20:   enc_word = i_word(6'b101011, cmd_rs, cmd_rt, cmd_imm);
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    full_d       = full_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_ill_d    = err_ill_q;
    err_ovf_d    = err_ovf_q;
    case (state_q)
      ST_LOAD: begin
        if (cmd_valid) begin
          // full_q means the top address already holds a word; anything more cannot fit.
          if (full_q) begin
            state_d   = ST_OVF;
            err_ovf_d = 1'b1;
          end else if (!enc_legal) begin
            err_ill_d = 1'b1;
            if (cmd_last) state_d = ST_DONE;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = addr_q;
            imem_wdata_d = enc_word;
            addr_d       = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) full_d = 1'b1;
            if (cmd_last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = ST_LOAD;
          addr_d    = BASE;
          full_d    = 1'b0;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end
    endcase
    done_d     = (state_d == ST_DONE);
    cpu_hold_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE;
      full_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE;
      imem_wdata_q <= 32'd0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_ill_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      full_q       <= full_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_ill_q    <= err_ill_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign cmd_ready  = (state_q == ST_LOAD);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err_ill    = err_ill_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_imem_boot_encoder.sv
// Directed self-checking bench for imem_boot_encoder: a default-width instance and an
// ADDR_W=2 instance share the same stimulus so address exhaustion can be exercised.
module tb_imem_boot_encoder;

  logic        clk = 1'b0;
  logic        reset, start, cmd_valid, cmd_last;
  logic [4:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;

  logic        cmd_ready, imem_we, cpu_hold, done, err_ill, err_ovf;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  logic        s_cmd_ready, s_imem_we, s_cpu_hold, s_done, s_err_ill, s_err_ovf;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_boot_encoder dut (
    .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_ill(err_ill), .err_ovf(err_ovf)
  );

  imem_boot_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_hold(s_cpu_hold), .done(s_done), .err_ill(s_err_ill), .err_ovf(s_err_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for exactly one clock edge, then drops valid.
  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] shamt,
                               input logic [15:0] imm, input logic [25:0] target,
                               input logic last);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_rs     = rs;
    cmd_rt     = rt;
    cmd_rd     = rd;
    cmd_shamt  = shamt;
    cmd_imm    = imm;
    cmd_target = target;
    cmd_last   = last;
    step();
    cmd_valid  = 1'b0;
    cmd_last   = 1'b0;
  endtask

  task automatic startSession();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"},    32'(imem_we),    32'd0);
    checkOutput({tag, "_addr"},  32'(imem_addr),  32'd0);
    checkOutput({tag, "_wdata"}, imem_wdata,      32'd0);
    checkOutput({tag, "_hold"},  32'(cpu_hold),   32'd1);
    checkOutput({tag, "_done"},  32'(done),       32'd0);
    checkOutput({tag, "_ill"},   32'(err_ill),    32'd0);
    checkOutput({tag, "_ovf"},   32'(err_ovf),    32'd0);
    checkOutput({tag, "_ready"}, 32'(cmd_ready),  32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_shamt = '0;
    cmd_imm = '0; cmd_target = '0;
    step();
    step();
    checkResetValues("rst");
    reset = 1'b0;
    step();
    checkOutput("idle_ready", 32'(cmd_ready), 32'd0);

    // Single ADD with last
    startSession();
    checkOutput("load_ready", 32'(cmd_ready), 32'd1);
    checkOutput("load_hold",  32'(cpu_hold),  32'd1);
    applyStimulus(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    checkOutput("add_we",    32'(imem_we),   32'd1);
    checkOutput("add_addr",  32'(imem_addr), 32'd0);
    checkOutput("add_data",  imem_wdata,     32'h00221820);
    checkOutput("add_done",  32'(done),      32'd1);
    checkOutput("add_hold",  32'(cpu_hold),  32'd0);
    step();
    checkOutput("add_we_off",  32'(imem_we),   32'd0);
    checkOutput("done_level",  32'(done),      32'd1);
    checkOutput("done_ready",  32'(cmd_ready), 32'd0);

    // Back-to-back BEQ, LW, J
    startSession();
    checkOutput("restart_done", 32'(done), 32'd0);
    applyStimulus(5'd13, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0);
    checkOutput("beq_addr", 32'(imem_addr), 32'd0);
    checkOutput("beq_data", imem_wdata,     32'h1085FFFE);
    applyStimulus(5'd19, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
    checkOutput("lw_we",   32'(imem_we),   32'd1);
    checkOutput("lw_addr", 32'(imem_addr), 32'd1);
    checkOutput("lw_data", imem_wdata,     32'h8FA80004);
    applyStimulus(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1);
    checkOutput("j_addr", 32'(imem_addr), 32'd2);
    checkOutput("j_data", imem_wdata,     32'h08000040);
    checkOutput("j_done", 32'(done),      32'd1);

    // SLL with garbage rs; JR with garbage rt/rd/shamt
    startSession();
    applyStimulus(5'd0, 5'd7, 5'd9, 5'd10, 5'd2, 16'h0, 26'h0, 1'b0);
    checkOutput("sll_data", imem_wdata, 32'h00095080);
    applyStimulus(5'd10, 5'd31, 5'd9, 5'd10, 5'd3, 16'hFFFF, 26'h0, 1'b1);
    checkOutput("jr_addr", 32'(imem_addr), 32'd1);
    checkOutput("jr_data", imem_wdata,     32'h03E00008);

    // Illegal op between two ADDIs
    startSession();
    applyStimulus(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
    checkOutput("addi1_addr", 32'(imem_addr), 32'd0);
    checkOutput("addi1_data", imem_wdata,     32'h20220005);
    applyStimulus(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
    checkOutput("ill_we",    32'(imem_we), 32'd0);
    checkOutput("ill_flag",  32'(err_ill), 32'd1);
    checkOutput("ill_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(5'd15, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1);
    checkOutput("addi2_addr", 32'(imem_addr), 32'd1);
    checkOutput("addi2_data", imem_wdata,     32'h2064FFFF);
    checkOutput("ill_done",   32'(done),      32'd1);
    checkOutput("ill_sticky", 32'(err_ill),   32'd1);

    // Overflow on the ADDR_W=2 instance: five commands, only four fit
    startSession();
    checkOutput("restart_ill_clr", 32'(err_ill), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      checkOutput($sformatf("small_we%0d", i),   32'(s_imem_we),   32'd1);
      checkOutput($sformatf("small_addr%0d", i), 32'(s_imem_addr), 32'(i));
    end
    applyStimulus(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    checkOutput("ovf_we",    32'(s_imem_we),   32'd0);
    checkOutput("ovf_addr",  32'(s_imem_addr), 32'd3);
    checkOutput("ovf_flag",  32'(s_err_ovf),   32'd1);
    checkOutput("ovf_hold",  32'(s_cpu_hold),  32'd1);
    checkOutput("ovf_done",  32'(s_done),      32'd0);
    checkOutput("ovf_ready", 32'(s_cmd_ready), 32'd0);
    checkOutput("big_addr4", 32'(imem_addr),   32'd4);
    checkOutput("big_done",  32'(done),        32'd1);

    // Restart from OVF clears the flag; then reset right after an accept
    startSession();
    checkOutput("ovf_cleared", 32'(s_err_ovf), 32'd0);
    applyStimulus(5'd5, 5'd6, 5'd7, 5'd8, 5'd0, 16'h0, 26'h0, 1'b0);
    checkOutput("and_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    step();
    checkResetValues("midrst");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
